// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, frame_buffer read addressing, 2-stage pixel pipeline
// and the vertical-blanking buffer swap pulse.
module vga_scanout #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int HOR_FRONT_PORCH   = 16,
  parameter int HOR_SYNC_PULSE    = 96,
  parameter int HOR_BACK_PORCH    = 48,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int VER_FRONT_PORCH   = 10,
  parameter int VER_SYNC_PULSE    = 2,
  parameter int VER_BACK_PORCH    = 33,
  parameter int SYNC_ACTIVE_LOW   = 1,
  localparam int HOR_TOTAL    = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH,
  localparam int VER_TOTAL    = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH,
  localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  input  logic                  frame_ready,
  output logic                  swap,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_de,
  output logic [3:0]            vga_red,
  output logic [3:0]            vga_green,
  output logic [3:0]            vga_blue
);

  localparam int HW = $clog2(HOR_TOTAL);
  localparam int VW = $clog2(VER_TOTAL);

  localparam logic [HW-1:0] H_ACT      = HW'(HOR_ACTIVE_PIXELS);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(HOR_TOTAL - 1);
  localparam logic [HW-1:0] HS_START   = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END     = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE);
  localparam logic [VW-1:0] V_ACT      = VW'(VER_ACTIVE_PIXELS);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(VER_ACTIVE_PIXELS - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VER_TOTAL - 1);
  localparam logic [VW-1:0] VS_START   = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END     = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE);
  localparam logic          SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          end_of_line, active0, hsync0, vsync0;
  logic          last_pixel, next_active, swap_edge;
  logic          de1, hs1, vs1;
  logic [3:0]    pix;

  always_comb begin
    end_of_line = (h_cnt == H_LAST);
    h_nxt       = end_of_line ? '0 : h_cnt + HW'(1);
    v_nxt       = v_cnt;
    if (end_of_line) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end
    active0     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync0      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vsync0      = (v_cnt >= VS_START) && (v_cnt < VS_END);
    last_pixel  = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
    // Frame start is excluded: the address is already 0 there and must not step.
    next_active = (h_nxt < H_ACT) && (v_nxt < V_ACT) && ((h_nxt != '0) || (v_nxt != '0));
    swap_edge   = end_of_line && (v_cnt == V_ACT_LAST);
  end

  assign pix       = {4{read_data & de1}};

  // read_data arrives one clk after read_addr with no handshake, so stage 1 only
  // carries the timing flags and stage 2 merges them with the returned pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      read_addr <= '0;
      swap      <= 1'b0;
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      vga_de    <= 1'b0;
      vga_hsync <= SYNC_IDLE;
      vga_vsync <= SYNC_IDLE;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (last_pixel) begin
        read_addr <= '0;
      end else if (next_active) begin
        read_addr <= read_addr + ADDR_WIDTH'(1);
      end
      swap      <= swap_edge & frame_ready;
      de1       <= active0;
      hs1       <= hsync0;
      vs1       <= vsync0;
      vga_de    <= de1;
      vga_hsync <= hs1 ^ SYNC_IDLE;
      vga_vsync <= vs1 ^ SYNC_IDLE;
      vga_red   <= pix;
      vga_green <= pix;
      vga_blue  <= pix;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a small-geometry instance in both sync polarities plus a
// full 640x480 instance, checked against hand vectors and an arithmetic raster model.
module tb_vga_scanout;

  typedef struct {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
  } geom_t;

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic        sw;
    logic [11:0] rgb;
    int          addr;
  } out_t;

  typedef struct {
    int          t;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sw;
    logic [11:0] rgb;
    int          addr;
  } vec_t;

  localparam geom_t GS = '{8, 2, 3, 3, 4, 2, 2, 2};
  localparam geom_t GD = '{640, 16, 96, 48, 480, 10, 2, 33};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_ready = 1'b1;
  int unsigned edges = 0;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  logic [4:0]  addr_a, addr_b;
  logic [18:0] addr_d;
  logic        rd_a, rd_b, rd_d;
  logic        sw_a, sw_b, sw_d;
  logic        hs_a, hs_b, hs_d, vs_a, vs_b, vs_d, de_a, de_b, de_d;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_d, g_d, b_d;

  vec_t vecs[24];

  vga_scanout #(
    .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(2), .HOR_SYNC_PULSE(3), .HOR_BACK_PORCH(3),
    .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(2), .VER_SYNC_PULSE(2), .VER_BACK_PORCH(2),
    .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .read_addr(addr_a), .read_data(rd_a), .frame_ready(frame_ready),
    .swap(sw_a), .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_de(de_a),
    .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a)
  );

  vga_scanout #(
    .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(2), .HOR_SYNC_PULSE(3), .HOR_BACK_PORCH(3),
    .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(2), .VER_SYNC_PULSE(2), .VER_BACK_PORCH(2),
    .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .read_addr(addr_b), .read_data(rd_b), .frame_ready(frame_ready),
    .swap(sw_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_de(de_b),
    .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b)
  );

  vga_scanout dut_d (
    .clk(clk), .rst_n(rst_n), .read_addr(addr_d), .read_data(rd_d), .frame_ready(frame_ready),
    .swap(sw_d), .vga_hsync(hs_d), .vga_vsync(vs_d), .vga_de(de_d),
    .vga_red(r_d), .vga_green(g_d), .vga_blue(b_d)
  );

  // clock / reset bookkeeping and frame_buffer models (data = addr[0], one clk late)
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  always @(posedge clk) begin
    rd_a <= addr_a[0];
    rd_b <= addr_b[0];
    rd_d <= addr_d[0];
  end

  function automatic int addr_at(geom_t g, int p);
    int ht, vt, q, h, v;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    q  = p % (ht * vt);
    h  = q % ht;
    v  = q / ht;
    if (v >= g.va) return 0;
    if (h < g.ha) return v * g.ha + h;
    if (v == g.va - 1) return 0;
    return v * g.ha + g.ha - 1;
  endfunction

  // t = posedges since reset release; syncs returned active-high; assumes frame_ready=1
  function automatic out_t exp_out(geom_t g, int t);
    out_t o;
    int ht, vt, p, q, h, v;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    o.addr = addr_at(g, t);
    o.sw   = (t >= 1) && (((t - 1) % (ht * vt)) == g.va * ht - 1);
    o.de   = 1'b0;
    o.hs   = 1'b0;
    o.vs   = 1'b0;
    o.rgb  = 12'h000;
    if (t >= 2) begin
      p = t - 2;
      q = p % (ht * vt);
      h = q % ht;
      v = q / ht;
      o.de = (h < g.ha) && (v < g.va);
      o.hs = (h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs);
      o.vs = (v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs);
      if (o.de && (addr_at(g, p) % 2 == 1)) o.rgb = 12'hfff;
    end
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, edges, got, exp);
    end
  endtask

  task automatic wait_edge(int t);
    int guard = 0;
    while (int'(edges) < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (int'(edges) != t) chk("wait_edge", 32'(edges), 32'(t));
  endtask

  task automatic do_reset(logic fr);
    @(negedge clk);
    rst_n = 1'b0;
    frame_ready = fr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_a_de",   32'(de_a), 32'(0));
    chk("rst_a_hs",   32'(hs_a), 32'(1));
    chk("rst_a_vs",   32'(vs_a), 32'(1));
    chk("rst_a_rgb",  32'({r_a, g_a, b_a}), 32'(0));
    chk("rst_a_addr", 32'(addr_a), 32'(0));
    chk("rst_a_swap", 32'(sw_a), 32'(0));
    chk("rst_b_hs",   32'(hs_b), 32'(0));
    chk("rst_b_vs",   32'(vs_b), 32'(0));
    chk("rst_b_swap", 32'(sw_b), 32'(0));
    chk("rst_d_de",   32'(de_d), 32'(0));
    chk("rst_d_hs",   32'(hs_d), 32'(1));
    chk("rst_d_vs",   32'(vs_d), 32'(1));
    chk("rst_d_rgb",  32'({r_d, g_d, b_d}), 32'(0));
    chk("rst_d_addr", 32'(addr_d), 32'(0));
  endtask

  task automatic check_all(int t);
    out_t ea, ed;
    ea = exp_out(GS, t);
    ed = exp_out(GD, t);
    chk("a_de",   32'(de_a), 32'(ea.de));
    chk("a_hs",   32'(hs_a), 32'(!ea.hs));
    chk("a_vs",   32'(vs_a), 32'(!ea.vs));
    chk("a_rgb",  32'({r_a, g_a, b_a}), 32'(ea.rgb));
    chk("a_addr", 32'(addr_a), 32'(ea.addr));
    chk("a_swap", 32'(sw_a), 32'(ea.sw));
    chk("b_hs",   32'(hs_b), 32'(ea.hs));
    chk("b_vs",   32'(vs_b), 32'(ea.vs));
    chk("b_de",   32'(de_b), 32'(ea.de));
    chk("d_de",   32'(de_d), 32'(ed.de));
    chk("d_hs",   32'(hs_d), 32'(!ed.hs));
    chk("d_vs",   32'(vs_d), 32'(!ed.vs));
    chk("d_rgb",  32'({r_d, g_d, b_d}), 32'(ed.rgb));
    chk("d_addr", 32'(addr_d), 32'(ed.addr));
    chk("d_swap", 32'(sw_d), 32'(ed.sw));
  endtask

  initial begin
    int sw_cnt, sw_t;

    // hand-computed checkpoints for the 16x10 geometry (pins lag the counters by 2)
    vecs = '{
      '{0,   1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{1,   1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1},
      '{2,   1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2},
      '{3,   1'b1, 1'b1, 1'b1, 1'b0, 12'hfff, 3},
      '{9,   1'b1, 1'b1, 1'b1, 1'b0, 12'hfff, 7},
      '{10,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 7},
      '{12,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 7},
      '{14,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 7},
      '{15,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 7},
      '{16,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 8},
      '{18,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 10},
      '{55,  1'b1, 1'b1, 1'b1, 1'b0, 12'hfff, 31},
      '{56,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{63,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{64,  1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 0},
      '{65,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{97,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{98,  1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 0},
      '{129, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 0},
      '{130, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{160, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 0},
      '{161, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1},
      '{162, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 2},
      '{224, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 0}
    };

    // long reset, then release on a falling edge
    repeat (10) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      wait_edge(vecs[i].t);
      chk("tbl_de",   32'(de_a), 32'(vecs[i].de));
      chk("tbl_hs",   32'(hs_a), 32'(vecs[i].hs));
      chk("tbl_vs",   32'(vs_a), 32'(vecs[i].vs));
      chk("tbl_swap", 32'(sw_a), 32'(vecs[i].sw));
      chk("tbl_rgb",  32'({r_a, g_a, b_a}), 32'(vecs[i].rgb));
      chk("tbl_addr", 32'(addr_a), 32'(vecs[i].addr));
    end

    // cycle-by-cycle sweep: many small frames and the first two full-size lines
    for (int t = 225; t < 1750; t++) begin
      wait_edge(t);
      check_all(t);
    end

    // asynchronous reset while a swap pulse is on the pin and a 640-wide line is active
    do_reset(1'b1);
    wait_edge(64);
    chk("swap_before_rst", 32'(sw_a), 32'(1));
    chk("d_de_before_rst", 32'(de_d), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset();

    // frame_ready only toggled away from the swap edges: no pulse
    do_reset(1'b0);
    sw_cnt = 0;
    for (int t = 1; t <= 330; t++) begin
      @(negedge clk);
      if (sw_a) sw_cnt++;
      if (sw_b) sw_cnt++;
      frame_ready = (t >= 20 && t < 40) || (t >= 70 && t < 150) || (t >= 170 && t < 223);
    end
    chk("no_swap_midframe", 32'(sw_cnt), 32'(0));

    // frame_ready high only across the swap edge: exactly one pulse at t=64
    do_reset(1'b0);
    sw_cnt = 0;
    sw_t = -1;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (sw_a) begin
        sw_cnt++;
        sw_t = t;
      end
      frame_ready = (t == 63);
    end
    chk("swap_once_cnt", 32'(sw_cnt), 32'(1));
    chk("swap_once_t",   32'(sw_t), 32'(64));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
